// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Byte/half/word loads with sign or zero extension; sub-word stores use a read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error instead of being aligned.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic [1:0]  req_off;
  logic        req_bad;

  // Pick the selected lane of a memory word and extend it to full width.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extend = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      2'b01:   load_extend = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the targeted byte or half of the fetched word with the store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] size,
                                                    input logic [15:0] wdata);
    logic [DATA_W-1:0] w;
    w = word;
    if (size == 2'b00) w[{off, 3'b000} +: 8] = wdata[7:0];
    else               w[{off[1], 4'b0000} +: 16] = wdata;
    return w;
  endfunction

  // Classify the incoming request: effective lane offset and error status.
  always_comb begin
    req_off = req_addr[1:0];
    req_bad = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])          req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
`else
    if (req_size == 2'b01) req_off[0] = 1'b0;
    if (req_size == 2'b10) req_off    = 2'b00;
`endif
  end

  // Only IDLE takes requests; forced low while reset is held.
  assign req_ready = (state == IDLE) && !rst;

  // Control FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_re     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q    <= req_off;
            size_q   <= req_size;
            we_q     <= req_we;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata[15:0];
            mem_addr <= req_addr >> 2;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_we && req_size == 2'b10) begin
              // Full-word store needs no read of the old contents.
              mem_wdata <= req_wdata;
              mem_wr    <= 1'b1;
              state     <= WR;
            end else begin
              mem_re <= 1'b1;
              state  <= RD;
            end
          end
        end
        RD: begin
          mem_re <= 1'b0;
          if (we_q) begin
            mem_wdata <= store_merge(mem_rdata, off_q, size_q, wdata_q);
            mem_wr    <= 1'b1;
            state     <= WR;
          end else begin
            resp_rdata <= load_extend(mem_rdata, off_q, size_q, uns_q);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_wr     <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the execute stage and the word-wide data memory.
- Accepts byte-addressed load/store requests over a valid/ready handshake and converts them to word-indexed mem_re/mem_wr accesses.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 64, width of request byte address and memory address bus.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU accepts request this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request.
- mem_re  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word index, equal to req_addr >> 2.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid at the rising edge ending the cycle in which mem_re is high.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready, resp_valid, resp_err, mem_re and mem_wr all 0; resp_rdata, mem_addr and mem_wdata are 0. Reset mid-operation aborts immediately, strobes drop combinationally with rst, and no response is produced.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. A transfer occurs on req_valid&req_ready. The request is latched (addr, size, we, unsigned, wdata); req_ready=0 in every other state.
- Transitions from IDLE on accept:
  - Error request: go to RESP with resp_err=1 and no memory strobe.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte/half store: go to RD.
- RD: mem_re=1, mem_addr=word index. Capture mem_rdata at the closing edge. A load goes to RESP. A sub-word store goes to WR.
- WR: mem_wr=1 for exactly one cycle, then go to RESP.
- mem_wdata rules:
  - Word store: req_wdata.
  - Sub-word store: captured word with the target lane(s) replaced by req_wdata low byte/half.
- Lanes are little-endian: byte k occupies bits [8k+7:8k], k=addr[1:0]; half at addr[1]=h occupies bits [16h+15:16h].
- Load result: selected lane extended per req_unsigned. Word loads are returned unchanged.
- RESP: resp_valid=1, holding resp_rdata and resp_err stable until resp_ready, then return to IDLE. req_ready is not asserted in the same cycle as the resp handshake, so there is no back-to-back overlap.
- Latency from accept edge to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- mem_re and mem_wr are never high together. Both are 0 outside RD/WR.
- req_size=11 is always an error regardless of macro.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, produces an error response with no memory access.
- Undefined: misaligned low address bits are forced to zero (half: addr[0]; word: addr[1:0]), the access proceeds aligned, and resp_err is only set for reserved size.

Test Plan:
- Reset mid-RD: assert rst while mem_re=1 -> mem_re=0 immediately; after release req_ready=1, resp_valid=0.
- Word store then load: store 0xDEADBEEF at addr 0x10 -> mem_wr one cycle, mem_addr=4, resp after 2 cycles; load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store RMW: memory word 4 = 0x11223344; store byte 0xAA at addr 0x12 -> RD then WR with mem_wdata=0x11AA3344; resp at 3 cycles.
- Sign/zero extend: word 4 = 0x0000F080; load half signed at 0x10 -> 0xFFFFF080; byte unsigned at 0x11 -> 0x000000F0.
- Misaligned: word load at 0x13.
  - With LSU_MISALIGN_TRAP_EN: resp_err=1, resp_rdata=0, no mem strobes.
  - Without the macro: access word 4, resp_err=0.
- Backpressure: hold resp_ready=0 for 5 cycles after load resp -> resp_valid and resp_rdata stable, req_ready=0, no strobes. Release -> IDLE next cycle.
